hex_keypad_entry: RTL and testbench



---
 rtl/hex_keypad_entry.sv | 181 ++++++++++++++++++
 tb/tb_hex_keypad_entry.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_entry.sv
// 4x4 matrix keypad scanner with sweep-based debounce.
// Each accepted key is shifted as a hex digit into a 16-bit entry register.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        RST,
  output logic [3:0]  KEY_ROW,
  input  logic [3:0]  KEY_COL,
  input  logic        CLR,
  output logic [15:0] HEXS,
  output logic [2:0]  ndigits,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int unsigned PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    DEB_N      = 8'(DEBOUNCE);
  localparam bit            DEB_ONE    = (DEBOUNCE == 1);

  // Sweep accumulator encoding: nothing seen, one key seen, ambiguous.
  localparam logic [1:0] HITS_NONE   = 2'd0;
  localparam logic [1:0] HITS_SINGLE = 2'd1;
  localparam logic [1:0] HITS_MULTI  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    row;
  logic [1:0]    acc_hits;
  logic [3:0]    acc_code;
  logic [3:0]    cand;
  logic [7:0]    cnt;
  logic [7:0]    rcnt;

  logic [3:0] col_low_c;
  logic [2:0] nlow_c;
  logic [1:0] col_idx_c;
  logic [1:0] row_nxt_c;
  logic [1:0] sweep_hits_c;
  logic [3:0] sweep_code_c;
  logic       is_last_c;
  logic       sweep_done_c;
  logic       sweep_single_c;
  logic       sweep_none_c;
  logic       accept_c;

  // Classify the current row sample and merge it into the sweep result.
  always_comb begin
    col_low_c = ~KEY_COL;
    nlow_c    = 3'(col_low_c[0]) + 3'(col_low_c[1]) + 3'(col_low_c[2]) + 3'(col_low_c[3]);
    col_idx_c = 2'd0;
    if (col_low_c[0])      col_idx_c = 2'd0;
    else if (col_low_c[1]) col_idx_c = 2'd1;
    else if (col_low_c[2]) col_idx_c = 2'd2;
    else if (col_low_c[3]) col_idx_c = 2'd3;

    sweep_hits_c = acc_hits;
    sweep_code_c = acc_code;
    if (nlow_c == 3'd1 && acc_hits == HITS_NONE) begin
      sweep_hits_c = HITS_SINGLE;
      sweep_code_c = {row, col_idx_c};
    end else if (nlow_c != 3'd0) begin
      sweep_hits_c = HITS_MULTI;
    end

    row_nxt_c      = row + 2'd1;
    is_last_c      = (presc == PRESC_LAST);
    sweep_done_c   = is_last_c && (row == 2'd3);
    sweep_single_c = (sweep_hits_c == HITS_SINGLE);
    sweep_none_c   = (sweep_hits_c == HITS_NONE);

    accept_c = 1'b0;
    if (sweep_done_c && sweep_single_c) begin
      if (state == IDLE && DEB_ONE)
        accept_c = 1'b1;
      else if (state == DEB && sweep_code_c == cand && (cnt + 8'd1) == DEB_N)
        accept_c = 1'b1;
    end
  end

  // Scanner, debounce FSM and digit register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      presc     <= '0;
      row       <= 2'd0;
      KEY_ROW   <= 4'b1110;
      acc_hits  <= HITS_NONE;
      acc_code  <= 4'd0;
      cand      <= 4'd0;
      cnt       <= 8'd0;
      rcnt      <= 8'd0;
      HEXS      <= 16'h0000;
      ndigits   <= 3'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= accept_c;
      if (accept_c)
        key_code <= sweep_code_c;

      if (is_last_c) begin
        presc   <= '0;
        row     <= row_nxt_c;
        KEY_ROW <= ~(4'b0001 << row_nxt_c);
        if (row == 2'd3) begin
          acc_hits <= HITS_NONE;
          acc_code <= 4'd0;
        end else begin
          acc_hits <= sweep_hits_c;
          acc_code <= sweep_code_c;
        end
      end else begin
        presc <= presc + PW'(1);
      end

      if (sweep_done_c) begin
        case (state)
          IDLE: begin
            if (sweep_single_c) begin
              cand <= sweep_code_c;
              if (DEB_ONE) begin
                state <= HELD;
                rcnt  <= 8'd0;
              end else begin
                state <= DEB;
                cnt   <= 8'd1;
              end
            end
          end
          DEB: begin
            if (!sweep_single_c) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else if (sweep_code_c != cand) begin
              cand <= sweep_code_c;
              cnt  <= 8'd1;
            end else if (accept_c) begin
              state <= HELD;
              cnt   <= 8'd0;
              rcnt  <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          HELD: begin
            if (sweep_none_c) begin
              if ((rcnt + 8'd1) == DEB_N) begin
                state <= IDLE;
                rcnt  <= 8'd0;
              end else begin
                rcnt <= rcnt + 8'd1;
              end
            end else begin
              rcnt <= 8'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Clear beats a coincident accept for the digit register only.
      if (CLR) begin
        HEXS    <= 16'h0000;
        ndigits <= 3'd0;
      end else if (accept_c) begin
        HEXS    <= {HEXS[11:0], sweep_code_c};
        ndigits <= (ndigits == 3'd4) ? 3'd4 : ndigits + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry: a keypad matrix model drives the columns,
// expected accepts go into a scoreboard that a monitor drains on key_valid.
module tb_hex_keypad_entry;

  localparam int unsigned SWEEP = 16;

  logic        clk = 1'b0;
  logic        RST;
  logic        CLR;
  logic [3:0]  KEY_ROW;
  logic [3:0]  KEY_COL;
  logic [15:0] HEXS;
  logic [2:0]  ndigits;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] key_mat;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] hexs;
    logic [2:0]  nd;
    int          at;
  } exp_t;

  exp_t sb[$];

  hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk      (clk),
    .RST      (RST),
    .KEY_ROW  (KEY_ROW),
    .KEY_COL  (KEY_COL),
    .CLR      (CLR),
    .HEXS     (HEXS),
    .ndigits  (ndigits),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: pressed key {row,col} pulls its column low while its row is driven.
  always_comb begin
    KEY_COL = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!KEY_ROW[r] && key_mat[r*4+c]) KEY_COL[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (RST === 1'b0 && key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_code", 32'(key_code), 32'(e.code));
        check("pulse_hexs", 32'(HEXS), 32'(e.hexs));
        check("pulse_ndigits", 32'(ndigits), 32'(e.nd));
        if (e.at >= 0) check("pulse_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Hold a key pattern for n sweeps; entry and exit at a negedge aligned to row 0, prescaler 0.
  task automatic run_sweeps(input logic [15:0] mat, input int n);
    key_mat = mat;
    repeat (SWEEP * n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
  endtask

  // Press for two sweeps (accept at the end of the second), then release for two.
  task automatic enter_key(input logic [3:0] k, input logic [15:0] hexs, input logic [2:0] nd);
    exp_t e;
    logic [15:0] m;
    m = 16'h0001 << k;
    e.code = k; e.hexs = hexs; e.nd = nd; e.at = cyc + 2 * SWEEP;
    sb.push_back(e);
    run_sweeps(m, 2);
    run_sweeps(16'h0000, 2);
  endtask

  initial begin
    exp_t e;
    logic [3:0] exp_row;
    RST = 1'b1; CLR = 1'b0; key_mat = 16'h0000;
    @(negedge clk);
    do_reset();
    check("rst_key_row", 32'(KEY_ROW), 32'h0000000E);
    check("rst_hexs", 32'(HEXS), 32'h0);
    check("rst_ndigits", 32'(ndigits), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);

    // Row drive walks one low bit every SCAN_DIV cycles.
    for (int i = 0; i < 3 * SWEEP; i++) begin
      exp_row = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
      check("scan_key_row", 32'(KEY_ROW), 32'(exp_row));
      @(posedge clk);
      @(negedge clk);
    end

    // Key 9 held four sweeps: one accept at the end of sweep two, none while held.
    e.code = 4'h9; e.hexs = 16'h0009; e.nd = 3'd1; e.at = cyc + 2 * SWEEP;
    sb.push_back(e);
    run_sweeps(16'h0200, 4);
    run_sweeps(16'h0000, 2);
    check("held_sb_drained", 32'(sb.size()), 32'd0);

    enter_key(4'h1, 16'h0091, 3'd1 + 3'd1);
    enter_key(4'h2, 16'h0912, 3'd3);
    enter_key(4'h3, 16'h9123, 3'd4);
    enter_key(4'h4, 16'h1234, 3'd4);
    enter_key(4'h5, 16'h2345, 3'd4);
    check("five_hexs", 32'(HEXS), 32'h00002345);
    check("five_ndigits", 32'(ndigits), 32'd4);

    // Bounce: single-sweep presses never reach the count.
    run_sweeps(16'h0002, 1);
    run_sweeps(16'h0000, 1);
    run_sweeps(16'h0002, 1);
    run_sweeps(16'h0000, 2);
    // Two columns in one row is ambiguous and ignored.
    run_sweeps(16'h0003, 3);
    run_sweeps(16'h0000, 1);
    check("bounce_multi_hexs", 32'(HEXS), 32'h00002345);
    check("bounce_multi_key_code", 32'(key_code), 32'h5);

    // Standalone clear, mid release sweep.
    key_mat = 16'h0000;
    CLR = 1'b1;
    @(posedge clk);
    @(negedge clk);
    CLR = 1'b0;
    check("clr_hexs", 32'(HEXS), 32'h0);
    check("clr_ndigits", 32'(ndigits), 32'h0);
    repeat (SWEEP - 1) @(posedge clk);
    @(negedge clk);

    enter_key(4'h1, 16'h0001, 3'd1);
    enter_key(4'h2, 16'h0012, 3'd2);
    enter_key(4'h3, 16'h0123, 3'd3);
    check("pre_clr_hexs", 32'(HEXS), 32'h00000123);

    // Key 7 accepted on the same edge CLR is high.
    e.code = 4'h7; e.hexs = 16'h0000; e.nd = 3'd0; e.at = cyc + 2 * SWEEP;
    sb.push_back(e);
    key_mat = 16'h0080;
    repeat (2 * SWEEP - 1) @(posedge clk);
    @(negedge clk);
    CLR = 1'b1;
    @(posedge clk);
    @(negedge clk);
    CLR = 1'b0;
    run_sweeps(16'h0000, 2);
    check("clr_accept_key_code", 32'(key_code), 32'h7);
    check("clr_accept_hexs", 32'(HEXS), 32'h0);

    // Reset after one debounce sweep drops the candidate.
    run_sweeps(16'h0400, 1);
    do_reset();
    check("rst2_key_row", 32'(KEY_ROW), 32'h0000000E);
    check("rst2_hexs", 32'(HEXS), 32'h0);
    check("rst2_key_code", 32'(key_code), 32'h0);
    check("rst2_key_valid", 32'(key_valid), 32'h0);
    run_sweeps(16'h0400, 1);
    run_sweeps(16'h0000, 2);
    check("rst2_no_pulse_hexs", 32'(HEXS), 32'h0);
    check("rst2_ndigits", 32'(ndigits), 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
